seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor. Operands are split into CHUNK-bit slices, and one slice is processed per clock, LSB first, through a registered carry. This is the sequential, width-generic successor of the 4-bit combinational ripple add/sub. A valid/ready handshake is used on both input and result, so the block can sit between datapath stages that tolerate multi-cycle latency.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per clock; CHUNK == WIDTH gives single-pass operation.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
start_valid  in  1  operands and op presented.
start_ready  out  1  block can accept an operation.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
sub  in  1  0: a+b; 1: a-b computed as a + ~b + 1.
res_valid  out  1  result fields valid.
res_ready  in  1  consumer takes the result.
s  out  WIDTH  sum/difference.
carry_out  out  1  carry from MSB; for sub, 1 means no borrow.
overflow  out  1  two's-complement signed overflow.
busy  out  1  high in RUN or DONE.

Behaviour:
- NCHUNK = WIDTH/CHUNK. FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at an edge): state=IDLE, s=0, carry_out=0, overflow=0, res_valid=0, chunk index=0, carry register=0.
- start_ready=1 only in IDLE with rst=0; start_ready=0 while rst is high.
- IDLE: on start_valid && start_ready:
  - latch a.
  - latch b XOR {WIDTH{sub}}.
  - carry register = sub.
  - chunk index = 0.
  - go to RUN.
  - start_valid while not ready is ignored and not queued.
- RUN, each edge:
  - s[k*CHUNK +: CHUNK] = a_k + b'_k + carry.
  - carry register = chunk carry; k++.
- RUN, on chunk NCHUNK-1:
  - carry_out = final carry.
  - overflow = (a_msb == b'_msb) && (s_msb != a_msb), where b' is the inverted-or-not operand.
  - res_valid=1; go to DONE.
- Latency: res_valid rises exactly NCHUNK edges after the accepting edge (1 edge when CHUNK==WIDTH).
- DONE: s/carry_out/overflow held stable while res_valid=1 and res_ready=0. On res_valid && res_ready: res_valid=0, go to IDLE. start_ready rises the following cycle; there is no same-cycle turnaround.
- s may hold partial bits during RUN and is meaningful only with res_valid. After handshake, s/carry_out/overflow retain their last values until the next completion.
- Arithmetic is modulo 2^WIDTH. Carry crosses chunk boundaries only via the carry register (e.g. 0xFFFF+1 ripples across all NCHUNK cycles).
- Operand ports may change after acceptance without effect.
- rst mid-RUN or in DONE: the operation is aborted, no res_valid is produced, and all outputs return to reset values at that edge.
- Signals are registered, except start_ready and busy, which are decoded from state.

Optional Feature:
- ADDSUB_SAT_EN defined: when signed overflow occurs, s is clamped at the completion edge. Positive overflow (a_msb=0) gives 0111...1; negative overflow gives 1000...0. The overflow flag is still reported, and carry_out is unchanged. Latency is unchanged.
- ADDSUB_SAT_EN undefined: s is the wrapped modulo result; no clamp logic is present.

Test Plan:
1. WIDTH=16, CHUNK=4: a=0x1234, b=0x0FFF, sub=0 -> s=0x2233, carry_out=0, overflow=0; res_valid exactly 4 edges after accept.
2. a=0xFFFF, b=0x0001, sub=0 -> s=0x0000, carry_out=1, overflow=0; carry ripples through all four chunks.
3. a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, carry_out=0 (borrow), overflow=0.
4. a=0x7FFF, b=0x0001, sub=0 -> overflow=1, carry_out=0, s=0x8000 (0x7FFF with ADDSUB_SAT_EN). Also a=0x8000, b=0x0001, sub=1 -> overflow=1, carry_out=1, s=0x7FFF (0x8000 with SAT).
5. Hold res_ready=0 for 5 cycles after completion with start_valid=1 -> s/flags stable, start_ready=0, no new accept. Then raise res_ready -> res_valid=0 next edge, start_ready=1 the cycle after.
6. Assert rst for 1 cycle after 2 RUN edges -> res_valid never rises, s=0, flags=0, start_ready=1 the cycle after rst drops. A following op (a=0x0001, b=0x0002, sub=0) gives s=0x0003.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB first, through a registered carry.
// Optional build macro ADDSUB_SAT_EN clamps s on signed overflow at completion.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx;

  logic [31:0]       base;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [CHUNK-1:0]  a_k;
  logic [CHUNK-1:0]  b_k;
  logic [CHUNK:0]    sum_k;
  logic [WIDTH-1:0]  chunk_mask;
  logic [WIDTH-1:0]  s_merged;
  logic              last;
  logic              ovf;

`ifdef ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign start_ready = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);

  // Slice selection by shifting keeps the datapath legal when CHUNK == WIDTH.
  assign base       = 32'(idx) * 32'(CHUNK);
  assign a_sh       = a_q >> base;
  assign b_sh       = b_q >> base;
  assign a_k        = a_sh[CHUNK-1:0];
  assign b_k        = b_sh[CHUNK-1:0];
  assign sum_k      = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
  assign chunk_mask = WIDTH'({CHUNK{1'b1}});
  assign s_merged   = (s & ~(chunk_mask << base)) | (WIDTH'(sum_k[CHUNK-1:0]) << base);
  assign last       = (idx == IDXW'(NCHUNK - 1));
  assign ovf        = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_merged[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      res_valid <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          s       <= s_merged;
          carry_q <= sum_k[CHUNK];
          idx     <= idx + 1'b1;
          if (last) begin
            carry_out <= sum_k[CHUNK];
            overflow  <= ovf;
            res_valid <= 1'b1;
            state     <= DONE;
`ifdef ADDSUB_SAT_EN
            if (ovf) s <= sat_value(a_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub (WIDTH=16, CHUNK=4) with a queue-based result scoreboard.
module tb_seq_addsub;
  localparam int W   = 16;
  localparam int C   = 4;
  localparam int NCH = W / C;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] s;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
    .s(s), .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
    logic [W-1:0] yb;
    logic [W:0]   full;
    exp_t         e;
    yb   = op ? ~y : y;
    full = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, op};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (x[W-1] == yb[W-1]) && (e.s[W-1] != x[W-1]);
`ifdef ADDSUB_SAT_EN
    if (e.o) e.s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic op);
    int n;
    n = 0;
    while (!start_ready && n < 20) begin
      tick();
      n++;
    end
    chk("start_ready_before_issue", start_ready, 1);
    a = aa; b = bb; sub = op; start_valid = 1'b1;
    sb.push_back(model(aa, bb, op));
    tick();
    start_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, NCH);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_s"}, s, e.s);
      chk({tag, "_carry"}, carry_out, e.c);
      chk({tag, "_ovf"}, overflow, e.o);
    end
  endtask

  task automatic handshake(input string tag);
    chk({tag, "_ready_in_done"}, start_ready, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, res_valid, 0);
    chk({tag, "_ready_after"}, start_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] s_hold;
    logic         c_hold;
    logic         o_hold;
    logic         seen;

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    tick();
    tick();
    chk("ready_in_reset", start_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", start_ready, 1);
    chk("rst_busy", busy, 0);

    issue(16'h1234, 16'h0FFF, 1'b0);
    chk("t1_busy", busy, 1);
    wait_result("t1");
    chk("t1_const_s", s, 16'h2233);
    handshake("t1");

    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_result("t2");
    chk("t2_const_carry", carry_out, 1);
    handshake("t2");

    issue(16'h0005, 16'h0007, 1'b1);
    wait_result("t3");
    chk("t3_const_s", s, 16'hFFFE);
    handshake("t3");

    issue(16'h7FFF, 16'h0001, 1'b0);
    wait_result("t4a");
    chk("t4a_const_ovf", overflow, 1);
    handshake("t4a");

    issue(16'h8000, 16'h0001, 1'b1);
    wait_result("t4b");
    chk("t4b_const_ovf", overflow, 1);
    handshake("t4b");

    // Back-pressure: result held while start_valid pushes a new op.
    issue(16'hA5A5, 16'h1111, 1'b0);
    wait_result("t5");
    s_hold = s; c_hold = carry_out; o_hold = overflow;
    start_valid = 1'b1; a = 16'h0101; b = 16'h0202; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", res_valid, 1);
      chk("t5_hold_s", s, s_hold);
      chk("t5_hold_flags", {carry_out, overflow}, {c_hold, o_hold});
      chk("t5_hold_ready", start_ready, 0);
    end
    start_valid = 1'b0;
    handshake("t5");
    chk("t5_no_extra_result", res_valid, 0);

    // Abort mid-RUN.
    issue(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_ready_in_rst", start_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("t6_valid", res_valid, 0);
    chk("t6_s", s, 0);
    chk("t6_flags", {carry_out, overflow}, 2'b00);
    chk("t6_ready", start_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("t6_no_valid_after_abort", seen, 0);
    issue(16'h0001, 16'h0002, 1'b0);
    wait_result("t6_next");
    chk("t6_next_const_s", s, 16'h0003);
    handshake("t6_next");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
